// File: rtl/mem_access_unit.sv
// Memory-stage bus responder: issues a req/ack transaction for loads and stores,
// stalls the pipeline while outstanding, and returns aligned/extended load data.
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_enable_in,
    input  logic                  mem_rw_in,
    input  logic                  mem_width_in,
    input  logic                  sign_extend_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    output logic                  stall_out,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_valid,
    output logic                  addr_error,
    output logic                  bus_error,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]            bus_be_q, bus_be_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
    logic                  load_valid_q, load_valid_d;
    logic                  bus_error_q, bus_error_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rw_q, rw_d;
    logic                  width_q, width_d;
    logic                  sign_q, sign_d;
    logic [1:0]            off_q, off_d;
    logic                  misaligned;

    function automatic logic [DATA_WIDTH-1:0] extract_load(
        input logic [DATA_WIDTH-1:0] word,
        input logic                  is_word,
        input logic [1:0]            off,
        input logic                  sx
    );
        logic [DATA_WIDTH-1:0] shifted;
        logic [7:0]            lane;
        shifted = word >> {off, 3'b000};
        lane    = shifted[7:0];
        if (is_word)
            return word;
        return {{(DATA_WIDTH-8){sx & lane[7]}}, lane};
    endfunction

    assign misaligned = mem_enable_in & mem_width_in & (addr_in[1:0] != 2'b00);
    assign addr_error = misaligned;
    assign stall_out  = ((state_q == IDLE) & mem_enable_in & ~misaligned) | (state_q == BUSY);

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        bus_error_d  = 1'b0;
        cnt_d        = cnt_q;
        rw_d         = rw_q;
        width_d      = width_q;
        sign_d       = sign_q;
        off_d        = off_q;
        case (state_q)
            IDLE: begin
                if (mem_enable_in && !misaligned) begin
                    state_d     = BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_rw_in;
                    bus_addr_d  = {addr_in[ADDR_WIDTH-1:2], 2'b00};
                    bus_be_d    = mem_width_in ? 4'b1111 : (4'b0001 << addr_in[1:0]);
                    bus_wdata_d = mem_width_in ? wdata_in : {4{wdata_in[7:0]}};
                    rw_d        = mem_rw_in;
                    width_d     = mem_width_in;
                    sign_d      = sign_extend_in;
                    off_d       = addr_in[1:0];
                    cnt_d       = '0;
                end
            end
            BUSY: begin
                if (bus_ack) begin
                    state_d      = DONE;
                    bus_req_d    = 1'b0;
                    load_data_d  = rw_q ? '0 : extract_load(bus_rdata, width_q, off_q, sign_q);
                    load_valid_d = ~rw_q;
                end else if (cnt_q == CNT_LAST) begin
                    // Ack never arrived: abandon the transaction and report it.
                    state_d     = DONE;
                    bus_req_d   = 1'b0;
                    load_data_d = '0;
                    bus_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= 4'b0000;
            bus_wdata_q  <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            bus_error_q  <= 1'b0;
            cnt_q        <= '0;
            rw_q         <= 1'b0;
            width_q      <= 1'b0;
            sign_q       <= 1'b0;
            off_q        <= 2'b00;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            bus_error_q  <= bus_error_d;
            cnt_q        <= cnt_d;
            rw_q         <= rw_d;
            width_q      <= width_d;
            sign_q       <= sign_d;
            off_q        <= off_d;
        end
    end

    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign bus_error  = bus_error_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-side responder for the execution-to-memory pipeline register. Accepts the memory-stage control bundle (enable, read/write, width, sign-extend) plus address and store data, runs a request/acknowledge transaction on the data-memory bus, stalls the pipeline while the transaction is outstanding, and returns aligned, extended load data to the write-back path. It also flags misaligned word accesses and bus timeouts to the exception logic.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width (block supports 32 only)
- TIMEOUT_CYCLES, 16, max BUSY cycles awaiting ack before bus error (≥2)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- mem_enable_in  in  1  memory access requested this cycle
- mem_rw_in  in  1  1 = store, 0 = load
- mem_width_in  in  1  1 = word, 0 = byte
- sign_extend_in  in  1  byte load: 1 = sign-extend, 0 = zero-extend
- addr_in  in  ADDR_WIDTH  byte address (ALU result)
- wdata_in  in  DATA_WIDTH  store data (byte store uses bits [7:0])
- stall_out  out  1  hold upstream pipeline
- load_data  out  DATA_WIDTH  extended load result, valid in DONE
- load_valid  out  1  one-cycle pulse with load_data
- addr_error  out  1  misaligned word access (combinational)
- bus_error  out  1  one-cycle pulse on timeout
- bus_req  out  1  registered request, held until ack/timeout
- bus_we  out  1  registered write enable
- bus_addr  out  ADDR_WIDTH  word-aligned address (low 2 bits 0)
- bus_be  out  4  byte enables
- bus_wdata  out  DATA_WIDTH  store data, lane-replicated for bytes
- bus_ack  in  1  transaction complete; sampled only in BUSY
- bus_rdata  in  DATA_WIDTH  read word, valid with bus_ack

## Operation
- States: IDLE, BUSY, DONE. Reset (rst_n low at edge): state IDLE, bus_req/bus_we/bus_be/bus_addr/bus_wdata/load_data = 0, load_valid = bus_error = 0, timeout counter 0.
- misaligned = mem_enable_in & mem_width_in & (addr_in[1:0] != 0).
- IDLE: if mem_enable_in & !misaligned → BUSY; register bus_req=1, bus_we=mem_rw_in, bus_addr={addr_in[ADDR_WIDTH-1:2],2'b00}, latch rw/width/sign/offset; counter cleared. Misaligned → stay IDLE, no bus activity, addr_error=1 that cycle.
- Byte enables: word → 4'b1111; byte → 4'b0001 << addr_in[1:0]. Byte store: bus_wdata = {4{wdata_in[7:0]}}; word store: wdata_in.
- BUSY: bus_ack=1 → capture data, drop bus_req, → DONE. Else counter++; counter == TIMEOUT_CYCLES-1 without ack → drop bus_req, → DONE with error flag.
- Load extraction: word → bus_rdata; byte → lane bus_rdata[8*off+7:8*off], extended per latched sign flag. Stores: load_data = 0.
- DONE: load_valid=1 for completed loads; bus_error=1 if timed out (load_valid=0, load_data=0); → IDLE unconditionally.
- stall_out = (IDLE & mem_enable_in & !misaligned) | BUSY. Low in DONE, so the pipeline register advances at end of DONE and the same request is never reissued.
- Ack in IDLE/DONE (late ack after timeout) ignored.
- Synchronous reset mid-transaction: IDLE next edge, bus_req drops, no pulses emitted.

## Timing
- Cycle 0 (IDLE, request seen): stall_out=1. Cycle 1: BUSY, bus_req=1. Ack in cycle k≥1 → DONE in k+1 with load_valid, stall_out=0. Min access = 2 stall cycles + DONE.
- Request inputs sampled only in IDLE; held stable upstream by stall_out, but block does not depend on that.
- Timeout: ack never arrives → bus_req high exactly TIMEOUT_CYCLES cycles, DONE on next.
- bus_* outputs registered; stall_out, addr_error combinational.

## Test plan
- Word load addr 0x100, ack on 3rd BUSY cycle, rdata 0xDEADBEEF → bus_addr 0x100, bus_be 1111, bus_we 0; load_data 0xDEADBEEF, load_valid 1 cycle; stall_out high 4 cycles.
- Byte load addr 0x103 sign_extend=1, rdata 0x80123456 → bus_be 1000, load_data 0xFFFFFF80; same with sign_extend=0 → 0x00000080.
- Byte store addr 0x202 wdata 0x000000A5, immediate ack → bus_addr 0x200, bus_be 0100, bus_wdata 0xA5A5A5A5, bus_we 1, load_valid 0.
- Word access addr 0x102 → addr_error 1 same cycle, stall_out 0, bus_req never rises.
- No ack, TIMEOUT_CYCLES=16 → bus_req high 16 cycles, bus_error pulse, load_valid 0; late ack afterwards ignored.
- rst_n low during BUSY → next edge IDLE, bus_req 0, stall_out 0, no load_valid/bus_error pulse.
